// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the single-CS SPI slave.
//                - spi_state_e : byte-framing FSM states
//                - SPI_MODE    : SPI mode served (3: CPOL=1, CPHA=1)
//                - SCK_IDLE_LVL: SCK idle level implied by SPI_MODE
//                - IDLE_FILL   : byte returned when nothing was queued
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  localparam int unsigned SPI_MODE     = 3;
  // CPOL is bit 1 of the mode number.
  localparam logic        SCK_IDLE_LVL = (SPI_MODE >= 2) ? 1'b1 : 1'b0;
  localparam logic [7:0]  IDLE_FILL    = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer for one asynchronous input, followed
//                by one delay flop used to produce single-cycle edge pulses.
//  Ports       : clk_i   - system clock
//                rst_ni  - synchronous active-low reset
//                d_i     - asynchronous input
//                level_o - synchronized level
//                rise_o  - one-cycle pulse on synchronized 0->1
//                fall_o  - one-cycle pulse on synchronized 1->0
//  Parameters  : STAGES  - synchronizer depth
//                RST_VAL - idle level loaded into every flop on reset
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      // Truncating cast drops the oldest stage; works for any STAGES >= 1.
      sync_q <= STAGES'({sync_q, d_i});
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_single_cs.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_single_cs
//  Description : SPI slave, mode 3, MSB first, oversampled by i_Clk (at least
//                4x SCK). Counts received bytes per chip-select assertion and
//                returns a queued byte (or a fill byte) on MISO.
//  Ports       : i_Clk / i_Rst_L          - clock, sync active-low reset
//                i_SPI_Clk/CS_n/MOSI      - asynchronous SPI inputs
//                o_SPI_MISO / _En         - serial out and pad enable
//                i_TX_Byte / i_TX_DV      - load the TX holding register
//                o_TX_Ready               - holding register empty
//                o_RX_DV / o_RX_Byte      - received byte and valid pulse
//                o_RX_Count               - byte index within current CS
//  Macro       : SPI_SLAVE_ECHO_EN - an empty holding register makes the next
//                byte echo the last received byte instead of 8'hFF.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_single_cs
  import spi_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_L,
  input  logic                                  i_SPI_Clk,
  input  logic                                  i_SPI_CS_n,
  input  logic                                  i_SPI_MOSI,
  output logic                                  o_SPI_MISO,
  output logic                                  o_SPI_MISO_En,
  input  logic [7:0]                            i_TX_Byte,
  input  logic                                  i_TX_DV,
  output logic                                  o_TX_Ready,
  output logic                                  o_RX_DV,
  output logic [7:0]                            o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count
);

  localparam int               CNT_W   = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES_PER_CS);

  // Synchronized SPI inputs. Only SCK edges matter, never its level.
  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_level, cs_fall, cs_rise_unused;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE_LVL)) u_sck_sync (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst_L),
    .d_i     (i_SPI_Clk),
    .level_o (sck_level_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst_L),
    .d_i     (i_SPI_CS_n),
    .level_o (cs_level),
    .rise_o  (cs_rise_unused),
    .fall_o  (cs_fall)
  );

  // MOSI gets the same depth as SCK so a sample taken on a detected rising
  // edge sees the data that was stable at the real edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) mosi_sync_q <= '0;
    else          mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, i_SPI_MOSI});
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State and datapath registers.
  spi_state_e       state_q, state_d;
  logic [7:0]       tx_q, tx_d;
  logic [6:0]       rx_sh_q, rx_sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             rx_dv_q, rx_dv_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             drain;
  logic [7:0]       empty_fill;

`ifdef SPI_SLAVE_ECHO_EN
  assign empty_fill = rx_byte_q;
`else
  assign empty_fill = IDLE_FILL;
`endif

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      tx_q        <= IDLE_FILL;
      rx_sh_q     <= '0;
      bit_q       <= '0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= 8'h00;
      cnt_q       <= '0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      bit_q       <= bit_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_sh_d     = rx_sh_q;
    bit_d       = bit_q;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    drain       = 1'b0;

    if (cs_level) begin
      // Deselected: any partial byte is dropped, the holding register stays.
      state_d = ST_IDLE;
      bit_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          tx_d    = hold_full_q ? hold_q : empty_fill;
          drain   = hold_full_q;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          // The leading falling edge of a byte precedes its first rising
          // edge; the MSB is already on MISO, so only later falls shift.
          if (sck_fall && (bit_q != 3'd0)) tx_d = {tx_q[6:0], 1'b1};
          if (sck_rise) begin
            rx_sh_d = {rx_sh_q[5:0], mosi_s};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rx_dv_d   = 1'b1;
              rx_byte_d = {rx_sh_q, mosi_s};
              cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
              state_d   = ST_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (drain) hold_full_d = 1'b0;
    // A strobe in the drain cycle refills the register that LOAD just
    // emptied, so o_TX_Ready never rises for that byte.
    if (i_TX_DV && (!hold_full_q || drain)) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end
  end

  assign o_SPI_MISO_En = ~cs_level;
  assign o_SPI_MISO    = cs_level ? 1'b1 : tx_q[7];
  assign o_TX_Ready    = ~hold_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_RX_Count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_single_cs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_single_cs
//  Description : Self-checking bench: mode-3 SPI master driving the slave,
//                transaction-level model of holding register / RX framing,
//                directed scenarios plus randomized chip-select transactions.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_single_cs;

  localparam int MAXB = 2;
  localparam int HALF = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          i_Rst_L;
  logic          i_SPI_Clk;
  logic          i_SPI_CS_n;
  logic          i_SPI_MOSI;
  logic          o_SPI_MISO;
  logic          o_SPI_MISO_En;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [CW-1:0] o_RX_Count;

  always #5 clk = ~clk;

  spi_slave_single_cs #(.MAX_BYTES_PER_CS(MAXB), .SYNC_STAGES(2)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (i_Rst_L),
    .i_SPI_Clk     (i_SPI_Clk),
    .i_SPI_CS_n    (i_SPI_CS_n),
    .i_SPI_MOSI    (i_SPI_MOSI),
    .o_SPI_MISO    (o_SPI_MISO),
    .o_SPI_MISO_En (o_SPI_MISO_En),
    .i_TX_Byte     (i_TX_Byte),
    .i_TX_DV       (i_TX_DV),
    .o_TX_Ready    (o_TX_Ready),
    .o_RX_DV       (o_RX_DV),
    .o_RX_Byte     (o_RX_Byte),
    .o_RX_Count    (o_RX_Count)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [7:0]    m_hold;
  logic          m_full;
  logic [7:0]    m_last_rx;
  logic [7:0]    m_rx_byte;
  logic [7:0]    exp_rx_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic [15:0]   dv_log[$];
  logic          prev_dv;
  logic          mon_en = 1'b0;
  logic [7:0]    m_tx[4];
  logic [7:0]    m_rx[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] fill_byte();
`ifdef SPI_SLAVE_ECHO_EN
    return m_last_rx;
`else
    return 8'hFF;
`endif
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!o_SPI_MISO_En) chk("miso_idle_high", 32'(o_SPI_MISO), 32'd1);
      if (o_RX_DV) begin
        dv_log.push_back({8'(o_RX_Count), o_RX_Byte});
        chk("rx_dv_one_cycle", 32'(prev_dv), 32'd0);
        if (exp_rx_q.size() == 0) begin
          chk("rx_dv_unexpected", 32'(o_RX_DV), 32'd0);
        end else begin
          m_rx_byte = exp_rx_q.pop_front();
          chk("rx_byte", 32'(o_RX_Byte), 32'(m_rx_byte));
          chk("rx_count", 32'(o_RX_Count), 32'(exp_cnt_q.pop_front()));
        end
      end else begin
        chk("rx_byte_hold", 32'(o_RX_Byte), 32'(m_rx_byte));
      end
      prev_dv = o_RX_DV;
    end
  end

  task automatic do_reset();
    mon_en     = 1'b0;
    i_Rst_L    = 1'b0;
    i_SPI_Clk  = 1'b1;
    i_SPI_CS_n = 1'b1;
    i_SPI_MOSI = 1'b0;
    i_TX_Byte  = 8'h00;
    i_TX_DV    = 1'b0;
    m_hold     = 8'h00;
    m_full     = 1'b0;
    m_last_rx  = 8'h00;
    m_rx_byte  = 8'h00;
    prev_dv    = 1'b0;
    exp_rx_q.delete();
    exp_cnt_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_rx_dv", 32'(o_RX_DV), 32'd0);
    chk("rst_rx_byte", 32'(o_RX_Byte), 32'h00);
    chk("rst_rx_count", 32'(o_RX_Count), 32'd0);
    chk("rst_tx_ready", 32'(o_TX_Ready), 32'd1);
    chk("rst_miso", 32'(o_SPI_MISO), 32'd1);
    chk("rst_miso_en", 32'(o_SPI_MISO_En), 32'd0);
    i_Rst_L = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic tx_strobe(input logic [7:0] b);
    @(negedge clk);
    i_TX_Byte = b;
    i_TX_DV   = 1'b1;
    if (!m_full) begin
      m_hold = b;
      m_full = 1'b1;
    end
    @(negedge clk);
    i_TX_DV = 1'b0;
    chk("tx_ready_after_strobe", 32'(o_TX_Ready), 32'(!m_full));
  endtask

  // One chip-select assertion: nbytes full bytes from m_tx, then an optional
  // partial byte of tail bits. The slave reloads at CS start and after every
  // full byte, so nbytes+1 reloads happen.
  task automatic do_cs(input int nbytes, input int tail);
    logic [7:0] exp_miso;
    logic [7:0] got;
    int         nb;
    @(negedge clk);
    i_SPI_CS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int l = 0; l <= nbytes; l++) begin
      exp_miso = m_full ? m_hold : fill_byte();
      m_full   = 1'b0;
      nb       = (l < nbytes) ? 8 : tail;
      if (nb == 8) begin
        exp_rx_q.push_back(m_tx[l]);
        exp_cnt_q.push_back((l + 1 > MAXB) ? CW'(MAXB) : CW'(l + 1));
      end
      got = 8'h00;
      for (int b = 0; b < nb; b++) begin
        i_SPI_Clk  = 1'b0;
        i_SPI_MOSI = m_tx[l][7-b];
        repeat (HALF) @(negedge clk);
        i_SPI_Clk = 1'b1;
        got = {got[6:0], o_SPI_MISO};
        if (b == 0) chk("miso_en_active", 32'(o_SPI_MISO_En), 32'd1);
        repeat (HALF) @(negedge clk);
      end
      if (nb == 8) begin
        m_rx[l] = got;
        chk("master_rx", 32'(got), 32'(exp_miso));
        m_last_rx = m_tx[l];
      end
    end
    repeat (HALF) @(negedge clk);
    i_SPI_CS_n = 1'b1;
    i_SPI_MOSI = 1'b0;
    repeat (3 * HALF) @(negedge clk);
    chk("rx_dv_missing", 32'(exp_rx_q.size()), 32'd0);
    exp_rx_q.delete();
    exp_cnt_q.delete();
    chk("rx_count_clear", 32'(o_RX_Count), 32'd0);
    chk("tx_ready_idle", 32'(o_TX_Ready), 32'(!m_full));
    chk("miso_en_idle", 32'(o_SPI_MISO_En), 32'd0);
  endtask

  int ns, nbytes, tail;

  initial begin
    do_reset();

    // Two bytes, nothing queued.
    dv_log.delete();
    m_tx[0] = 8'h03; m_tx[1] = 8'hAD;
    do_cs(2, 0);
    chk("s1_dv_n", 32'(dv_log.size()), 32'd2);
    chk("s1_dv0", 32'(dv_log[0]), 32'h0103);
    chk("s1_dv1", 32'(dv_log[1]), 32'h02AD);
`ifdef SPI_SLAVE_ECHO_EN
    chk("s1_miso0", 32'(m_rx[0]), 32'h00);
    chk("s1_miso1", 32'(m_rx[1]), 32'h03);
`else
    chk("s1_miso0", 32'(m_rx[0]), 32'hFF);
    chk("s1_miso1", 32'(m_rx[1]), 32'hFF);
`endif

    // Queued byte is returned and the holding register empties.
    tx_strobe(8'hBE);
    chk("s2_ready_low", 32'(o_TX_Ready), 32'd0);
    m_tx[0] = 8'hEF;
    do_cs(1, 0);
    chk("s2_miso", 32'(m_rx[0]), 32'hBE);
    chk("s2_ready_high", 32'(o_TX_Ready), 32'd1);

    // Aborted partial byte, then a clean byte.
    dv_log.delete();
    m_tx[0] = 8'hC3;
    do_cs(0, 5);
    chk("s3_no_dv", 32'(dv_log.size()), 32'd0);
    m_tx[0] = 8'h5A;
    do_cs(1, 0);
    chk("s3_dv_n", 32'(dv_log.size()), 32'd1);
    chk("s3_dv0", 32'(dv_log[0]), 32'h015A);

    // Strobe while not ready is ignored.
    tx_strobe(8'h22);
    tx_strobe(8'h11);
    m_tx[0] = 8'h77;
    do_cs(1, 0);
    chk("s4_miso", 32'(m_rx[0]), 32'h22);

    // Count saturates.
    dv_log.delete();
    m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
    do_cs(3, 0);
    chk("s5_dv_n", 32'(dv_log.size()), 32'd3);
    chk("s5_dv0", 32'(dv_log[0]), 32'h0111);
    chk("s5_dv1", 32'(dv_log[1]), 32'h0222);
    chk("s5_dv2", 32'(dv_log[2]), 32'h0233);

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      ns = $urandom_range(0, 2);
      for (int s = 0; s < ns; s++) tx_strobe(8'($urandom));
      for (int k = 0; k < 4; k++) m_tx[k] = 8'($urandom);
      nbytes = $urandom_range(0, 3);
      tail   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      do_cs(nbytes, tail);
    end

`ifdef SPI_SLAVE_ECHO_EN
    // Echo of the last received byte, starting from the reset value.
    do_reset();
    m_tx[0] = 8'hA5; m_tx[1] = 8'h00;
    do_cs(2, 0);
    chk("echo_miso0", 32'(m_rx[0]), 32'h00);
    chk("echo_miso1", 32'(m_rx[1]), 32'hA5);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_single_cs.md
SPI_SLAVE_SINGLE_CS -- requirements
Module: spi_slave_single_cs

Interface
REQ-001 SHALL have parameter MAX_BYTES_PER_CS, default 2, maximum bytes counted per chip-select assertion.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI input.
REQ-003 SHALL have the following ports, clock and reset first.
  i_Clk  input  1  system clock, single clock domain.
  i_Rst_L  input  1  reset, synchronous, active-low.
  i_SPI_Clk  input  1  SPI clock from the master, mode 3 (CPOL=1, CPHA=1), asynchronous to i_Clk.
  i_SPI_CS_n  input  1  chip select, active-low.
  i_SPI_MOSI  input  1  serial data in, MSB first.
  o_SPI_MISO  output  1  serial data out, MSB first.
  o_SPI_MISO_En  output  1  MISO output enable, for the pad tristate.
  i_TX_Byte  input  8  next byte to return on MISO.
  i_TX_DV  input  1  one-cycle load strobe for i_TX_Byte.
  o_TX_Ready  output  1  TX holding register empty.
  o_RX_DV  output  1  one-cycle pulse, received byte valid.
  o_RX_Byte  output  8  received byte.
  o_RX_Count  output  $clog2(MAX_BYTES_PER_CS+1)  index of the byte within the current CS assertion.

Function
REQ-004 SHALL pass i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI through SYNC_STAGES flops each, then detect edges with one extra delay stage.
REQ-005 SHALL operate correctly when i_Clk is at least 4x the SPI clock frequency (half bit >= 2 i_Clk cycles).
REQ-006 SHALL implement an FSM with states IDLE, LOAD, SHIFT.
  IDLE: synced CS high.
  IDLE->LOAD: synced CS falling edge.
  LOAD->SHIFT: after exactly 1 cycle.
  SHIFT->LOAD: after the 8th synced SCK rising edge.
  Any state->IDLE: synced CS high.
REQ-007 In LOAD, SHALL copy the holding register into the TX shift register when it is full, clear it, and raise o_TX_Ready; when the holding register is empty, SHALL load 8'hFF.
REQ-008 In SHIFT, SHALL sample synced MOSI into the RX shift register on each synced SCK rising edge and increment a 3-bit bit counter.
REQ-009 In SHIFT, SHALL present the next TX bit on o_SPI_MISO at each synced SCK falling edge; the MSB SHALL be on o_SPI_MISO from LOAD onward.
REQ-010 SHALL assert o_RX_DV for exactly 1 cycle, with o_RX_Byte updated, in the cycle after the 8th rising edge is detected; o_RX_Byte SHALL hold that value until the next update.
REQ-011 SHALL increment o_RX_Count with each o_RX_DV, saturate it at MAX_BYTES_PER_CS, and clear it to 0 on CS deassertion.
REQ-012 SHALL accept i_TX_DV only when o_TX_Ready=1, in which case the holding register SHALL load and o_TX_Ready SHALL drop the next cycle; i_TX_DV while o_TX_Ready=0 SHALL be ignored.
REQ-013 When i_TX_DV and a LOAD holding-register drain fall in the same cycle, SHALL send the old byte, store the new one, and keep o_TX_Ready=0.
REQ-014 On CS deassertion mid-byte, SHALL discard the partial byte (no o_RX_DV), clear the bit counter, and keep the holding register contents.
REQ-015 SHALL drive o_SPI_MISO_En = NOT synced CS, and o_SPI_MISO=1 whenever o_SPI_MISO_En=0.

Reset
REQ-016 When i_Rst_L=0 at a rising i_Clk edge, SHALL set:
  FSM to IDLE.
  o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Count=0.
  o_TX_Ready=1, holding register empty.
  o_SPI_MISO=1, o_SPI_MISO_En=0.
  Synchronizers to idle levels (SCK=1, CS_n=1, MOSI=0).
REQ-017 Reset during a transfer SHALL abort it without emitting o_RX_DV; the block SHALL stay in IDLE until a fresh CS falling edge.

Configuration
REQ-018 With macro SPI_SLAVE_ECHO_EN defined, LOAD with an empty holding register SHALL load the last received byte (8'h00 after reset); without the macro it SHALL load 8'hFF.

Structure
REQ-019 Package spi_pkg SHALL hold the FSM state enum, the SPI_MODE=3 constant and the 8'hFF idle-fill constant.
REQ-020 A sub-module spi_sync_edge (synchronizer plus rise/fall pulse outputs, reset value as a parameter) SHALL be instantiated for SCK and for CS_n.

Verification
REQ-021 The bench SHALL drive the block with the team's SPI master (mode 3, CLKS_PER_HALF_BIT=4, MAX_BYTES_PER_CS=2) and cover:
  - Master sends 8'h03 then 8'hAD in one CS, no TX loaded -> o_RX_DV twice with o_RX_Byte 8'h03 (count 1) then 8'hAD (count 2); master receives 8'hFF, 8'hFF.
  - i_TX_Byte=8'hBE strobed before CS, master sends 8'hEF -> master receives 8'hBE; o_TX_Ready returns to 1 at LOAD.
  - CS deasserted after 5 bits -> no o_RX_DV; the next full byte 8'h5A is received correctly with o_RX_Count=1.
  - i_TX_DV with 8'h11 while o_TX_Ready=0 -> ignored; the earlier byte 8'h22 is sent.
  - Three bytes in one CS -> o_RX_Count reads 1, 2, 2 (saturated).
  - With SPI_SLAVE_ECHO_EN: send 8'hA5 then 8'h00, no TX loaded -> master receives 8'h00, then 8'hA5.
